// File: rtl/io_loader.sv
// Purpose : turns a framed byte stream {cmd, len, payload...} into single-byte write strobes for the io register file.
// Latency : 1 cycle from payload-byte accept to we/addr/data_o; done coincides with the last write.
// Backpres: in_ready high in IDLE/LEN/DATA (1 byte/cycle), low for the single DONE cycle and while abort=1.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_data    - input byte stream, accepted when in_ready is also high
//   in_ready            - loader can take a byte this cycle
//   abort               - synchronous frame abort, returns to IDLE without completing
//   we/addr/data_o      - registered write strobe, address and data towards io
//   reg_sel             - register bank select, held from one command byte to the next
//   busy                - frame in progress (LEN, DATA or DONE)
//   done                - one-cycle frame completion pulse
//   frame_cnt           - completed frame count, wraps at 8 bits
module io_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              abort,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        reg_sel,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LEN  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Counter is one bit wider than the address so it can hold the full
    // register-file size (32 for ADDR_W=5).
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_LEN   = CNT_W'(2 ** ADDR_W);
    localparam logic [DATA_W-1:0] MAX_LEN_D = DATA_W'(2 ** ADDR_W);

    logic [1:0]        state_q,     state_d;
    logic              rdy_q,       rdy_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [1:0]        reg_sel_q,   reg_sel_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              accept;
    logic [CNT_W-1:0]  len_eff;

    // abort masks readiness combinationally so the byte presented alongside
    // it is never consumed.
    assign in_ready = rdy_q & ~abort;
    assign accept   = in_valid & in_ready;

    // Length 0 means a full register file; anything larger saturates.
    always_comb begin
        len_eff = in_data[CNT_W-1:0];
        if (in_data == '0 || in_data > MAX_LEN_D) begin
            len_eff = MAX_LEN;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        reg_sel_d   = reg_sel_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    reg_sel_d = in_data[DATA_W-1 -: 2];
                    wr_addr_d = in_data[ADDR_W-1:0];
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    cnt_d   = len_eff;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d      = 1'b1;
                    addr_d    = wr_addr_q;
                    data_d    = in_data;
                    wr_addr_d = wr_addr_q + 1'b1;   // wraps naturally at 2^ADDR_W
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                // S_DONE: the frame is already complete, so it is counted
                // even if abort happens to be high in this cycle.
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Registered ready: low only for the cycle spent in DONE, and low out of
    // reset until the first clock edge.
    assign rdy_d = (state_d != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            reg_sel_q   <= 2'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            reg_sel_q   <= reg_sel_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign data_o    = data_q;
    assign reg_sel   = reg_sel_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_io_loader.sv
// Purpose : directed self-checking bench for io_loader.
// Latency : writes are logged at the falling edge, one entry per we cycle.
// Backpres: byte sender retries until in_ready is seen high, bounded per byte.
module tb_io_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       abort = 1'b0;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data_o;
    logic [1:0] reg_sel;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int last_tries = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Write log captured by the monitor.
    int         q_cyc[$];
    logic [4:0] q_addr[$];
    logic [7:0] q_data[$];
    logic [1:0] q_sel[$];
    logic       q_done[$];

    io_loader #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .abort     (abort),
        .we        (we),
        .addr      (addr),
        .data_o    (data_o),
        .reg_sel   (reg_sel),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (we) begin
            q_cyc.push_back(cyc);
            q_addr.push_back(addr);
            q_data.push_back(data_o);
            q_sel.push_back(reg_sel);
            q_done.push_back(done);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until it is accepted at a rising edge.
    task automatic send(input logic [7:0] b);
        int  tries;
        logic ok;
        tries = 0;
        ok    = 1'b0;
        do begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            #1 ok = in_ready;
            @(posedge clk);
            tries++;
        end while (!ok && tries < 20);
        last_tries = tries;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int b;
        int d0;
        logic [7:0] pay6 [0:5];

        // ---- reset state ----
        #2;
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_sel", 32'(reg_sel), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_rdy", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", 32'(in_ready), 0);
        @(posedge clk);
        #1 chk("rdy_after_edge", 32'(in_ready), 1);

        // ---- T1: basic frame, back-to-back ----
        b = q_addr.size(); d0 = done_cnt;
        send(8'h43); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        idle(3);
        chk("t1_nwr", 32'(q_addr.size() - b), 3);
        chk("t1_a0", 32'(q_addr[b]), 3);   chk("t1_d0", 32'(q_data[b]), 32'hAA);
        chk("t1_a1", 32'(q_addr[b+1]), 4); chk("t1_d1", 32'(q_data[b+1]), 32'hBB);
        chk("t1_a2", 32'(q_addr[b+2]), 5); chk("t1_d2", 32'(q_data[b+2]), 32'hCC);
        chk("t1_sel", 32'(q_sel[b+1]), 1);
        chk("t1_consec1", 32'(q_cyc[b+1] - q_cyc[b]), 1);
        chk("t1_consec2", 32'(q_cyc[b+2] - q_cyc[b+1]), 1);
        chk("t1_done_early", 32'(q_done[b+1]), 0);
        chk("t1_done_last", 32'(q_done[b+2]), 1);
        chk("t1_ndone", 32'(done_cnt - d0), 1);
        chk("t1_fcnt", 32'(frame_cnt), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_hold_addr", 32'(addr), 5);
        chk("t1_hold_data", 32'(data_o), 32'hCC);

        // ---- T2: address wrap ----
        b = q_addr.size(); d0 = done_cnt;
        send(8'h1E); send(8'h04);
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        idle(3);
        chk("t2_nwr", 32'(q_addr.size() - b), 4);
        chk("t2_a0", 32'(q_addr[b]), 30);
        chk("t2_a1", 32'(q_addr[b+1]), 31);
        chk("t2_a2", 32'(q_addr[b+2]), 0);
        chk("t2_a3", 32'(q_addr[b+3]), 1);
        chk("t2_d3", 32'(q_data[b+3]), 32'h13);
        chk("t2_sel", 32'(q_sel[b]), 0);
        chk("t2_ndone", 32'(done_cnt - d0), 1);
        chk("t2_fcnt", 32'(frame_cnt), 2);

        // ---- T3: length 0 means 32, then next frame right after DONE ----
        b = q_addr.size();
        send(8'h00); send(8'h00);
        for (int i = 0; i < 32; i++) send(8'(i));
        send(8'h80);
        chk("t3_bubble_tries", 32'(last_tries), 2);
        send(8'h01); send(8'h55);
        idle(3);
        chk("t3_nwr", 32'(q_addr.size() - b), 33);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t3_a%0d", i), 32'(q_addr[b+i]), 32'(i));
            chk($sformatf("t3_d%0d", i), 32'(q_data[b+i]), 32'(i));
        end
        chk("t3_next_a", 32'(q_addr[b+32]), 0);
        chk("t3_next_d", 32'(q_data[b+32]), 32'h55);
        chk("t3_next_sel", 32'(q_sel[b+32]), 2);
        chk("t3_fcnt", 32'(frame_cnt), 4);

        // ---- T4: gaps in in_valid ----
        b = q_addr.size(); d0 = done_cnt;
        send(8'h05);
        idle($urandom_range(0, 3));
        send(8'h05);
        for (int i = 0; i < 5; i++) begin
            idle($urandom_range(0, 3));
            send(8'(8'h60 + i));
        end
        idle(3);
        chk("t4_nwr", 32'(q_addr.size() - b), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_a%0d", i), 32'(q_addr[b+i]), 32'(5 + i));
            chk($sformatf("t4_d%0d", i), 32'(q_data[b+i]), 32'(8'h60 + i));
        end
        chk("t4_ndone", 32'(done_cnt - d0), 1);
        chk("t4_fcnt", 32'(frame_cnt), 5);

        // ---- T5: length above 32 saturates ----
        b = q_addr.size();
        send(8'h00); send(8'h21);
        for (int i = 0; i < 32; i++) send(8'(8'hA5 ^ i));
        idle(3);
        chk("t5_nwr", 32'(q_addr.size() - b), 32);
        chk("t5_last_a", 32'(q_addr[q_addr.size()-1]), 31);
        chk("t5_fcnt", 32'(frame_cnt), 6);
        chk("t5_busy", 32'(busy), 0);

        // ---- T6: abort on 3rd payload byte ----
        pay6[0] = 8'hD0; pay6[1] = 8'hD1; pay6[2] = 8'hD2;
        b = q_addr.size(); d0 = done_cnt;
        send(8'hC8); send(8'h06); send(pay6[0]); send(pay6[1]);
        @(negedge clk);
        in_valid = 1'b1; in_data = pay6[2]; abort = 1'b1;
        #1 chk("t6_rdy_masked", 32'(in_ready), 0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1 chk("t6_busy", 32'(busy), 0);
        idle(3);
        chk("t6_nwr", 32'(q_addr.size() - b), 2);
        chk("t6_a1", 32'(q_addr[b+1]), 9);
        chk("t6_d1", 32'(q_data[b+1]), 32'hD1);
        chk("t6_sel", 32'(q_sel[b]), 3);
        chk("t6_ndone", 32'(done_cnt - d0), 0);
        chk("t6_fcnt", 32'(frame_cnt), 6);
        b = q_addr.size();
        send(8'h41); send(8'h01); send(8'h77);
        idle(3);
        chk("t6n_nwr", 32'(q_addr.size() - b), 1);
        chk("t6n_a", 32'(q_addr[b]), 1);
        chk("t6n_d", 32'(q_data[b]), 32'h77);
        chk("t6n_sel", 32'(q_sel[b]), 1);
        chk("t6n_fcnt", 32'(frame_cnt), 7);

        // ---- T7: reset mid-DATA ----
        send(8'h82); send(8'h04); send(8'hE0); send(8'hE1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t7_we", 32'(we), 0);
        chk("t7_addr", 32'(addr), 0);
        chk("t7_data", 32'(data_o), 0);
        chk("t7_sel", 32'(reg_sel), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_rdy", 32'(in_ready), 0);
        chk("t7_fcnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t7_rdy_rel", 32'(in_ready), 0);
        @(posedge clk);
        #1 chk("t7_rdy_edge", 32'(in_ready), 1);
        b = q_addr.size(); d0 = done_cnt;
        send(8'h03); send(8'h01); send(8'h99);
        idle(3);
        chk("t7_nwr", 32'(q_addr.size() - b), 1);
        chk("t7_a", 32'(q_addr[b]), 3);
        chk("t7_d", 32'(q_data[b]), 32'h99);
        chk("t7_ndone", 32'(done_cnt - d0), 1);
        chk("t7_fcnt2", 32'(frame_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
